param_txn_gen: RTL
==================

# param_txn_gen

Type-parameterized burst transaction generator that sits directly upstream of the type-parameterized `mydesign` consumer. It produces the `pulse` strobe together with `ADDR`- and `DATA`-typed payloads, and uses the same type parameters so that a single instance pairs with any consumer configuration. A start command issues a burst of `len` beats over a valid/ready handshake. Addresses advance by a stride and data increments from a seed.

## Interface
- `MSB`, default 4: burst-length field is `[MSB:0]`; maximum burst is 2^(MSB+1)-1 beats.
- `ADDR`, type, default `bit[31:0]`: address type. Must be an integral packed type.
- `DATA`, type, default `logic[7:0]`: data type. Must be an integral packed type.
- `clk` input, 1: sole clock, rising edge.
- `rstn` input, 1: asynchronous active-low reset.
- `start` input, 1: launch a burst. Sampled only in IDLE.
- `abort` input, 1: terminate the burst in progress.
- `base_addr` input, `ADDR`: first beat address, captured on accepted start.
- `stride` input, `ADDR`: address increment per beat, captured on accepted start.
- `seed` input, `DATA`: first beat data, captured on accepted start.
- `len` input, `[MSB:0]`: beat count, captured on accepted start.
- `ready` input, 1: consumer accepts the current beat.
- `pulse` output, 1: beat valid.
- `addr` output, `ADDR`: current beat address.
- `data` output, `DATA`: current beat data.
- `beat_idx` output, `[MSB:0]`: index of the current beat.
- `busy` output, 1: state is not IDLE.
- `done` output, 1: one-cycle completion strobe.

## Operation
- Reset value of every output is 0, and the state is IDLE.
- States:
  - IDLE: `start`=1 with `abort`=0 captures the inputs. Go to RUN if `len`≠0, otherwise go to DONE.
  - RUN: `pulse`=1. A beat transfers when `pulse`&&`ready`. After the transfer of beat `len-1`, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Beat i drives:
  - `addr` = `base_addr` + i·`stride`, modulo 2^$bits(`ADDR`).
  - `data` = `seed` + i, modulo 2^$bits(`DATA`).
- All arithmetic is unsigned on the raw bit vector, with no sign extension. The next address is computed by accumulation, not by multiplication.
- `addr`, `data` and `beat_idx` hold stable while `pulse`=1 and `ready`=0.
- `start` is ignored while `busy`=1.
- `abort` in RUN: go to IDLE next cycle. `pulse` drops and no `done` is issued.
  - If `abort` coincides with a transfer, that beat counts as delivered.
  - `abort` in IDLE or DONE is ignored.
  - `start` and `abort` together in IDLE: `abort` wins and no burst starts.
- Reset asserted mid-burst: all outputs return to 0 asynchronously and the burst is lost.

## Timing
- Start latency: `start` sampled at edge N makes `pulse`=1 with beat 0 valid from N+1.
- Throughput: 1 beat per cycle while `ready`=1. With `ready` held high, a `len`-beat burst occupies cycles N+1..N+`len`. `done` is 1 in cycle N+`len`+1, and `busy` returns to 0 in N+`len`+2.
- `len`=0: `done` is 1 in cycle N+1 and no `pulse` is issued.
- The earliest next start is sampled in the first IDLE cycle after DONE.
- All outputs are registered, with no combinational path from `ready` to any output.

## Configuration
- `TXN_GEN_STATS_EN` defined:
  - Adds output port `beat_total` [31:0], which counts every transferred beat since reset.
  - The counter saturates at 32'hFFFF_FFFF, resets to 0, and is unaffected by `abort`.
- `TXN_GEN_STATS_EN` undefined: the port and the counter are absent, with no other behavioural difference.

## Structure
- Package `txn_gen_pkg` holds:
  - the state enum typedef (`IDLE`, `RUN`, `DONE`);
  - the constant `STATS_W` = 32.
- Sub-module `txn_addr_step`, parameterized by the same `ADDR` and `DATA` types, holds the `addr`/`data` accumulators with load (start) and step (transfer) controls.
- The top level holds the FSM, `beat_idx` and the optional stats counter.

## Test plan
- Default types:
  - Stimulus: `base_addr`=32'h1000, `stride`=4, `seed`=8'hA0, `len`=4, `ready`=1.
  - Response: `addr` 1000/1004/1008/100C with `data` A0/A1/A2/A3 in cycles N+1..N+4, and `done` at N+5.
- Backpressure:
  - Stimulus: same burst with `ready`=0 for 3 cycles during beat 1.
  - Response: `addr`=32'h1004, `data`=8'hA1 and `beat_idx`=1 hold; exactly 4 beats transfer, and `done` comes 3 cycles later than in the previous scenario.
- Wrap:
  - Stimulus: `base_addr`=32'hFFFF_FFF8, `stride`=8, `seed`=8'hFE, `len`=3.
  - Response: `addr` FFFF_FFF8/0000_0000/0000_0008 and `data` FE/FF/00.
  - Also with `ADDR`=`shortint`: `base_addr`=16'h7FFE, `stride`=1 gives 7FFE/7FFF/8000.
- Zero length and ignored start:
  - Stimulus: `len`=0.
  - Response: no `pulse`, `done` at N+1.
  - Stimulus: `start` pulsed while in RUN.
  - Response: ignored; the burst content is unchanged.
- Abort:
  - Stimulus: `abort` in the same cycle as the beat-1 transfer of a 4-beat burst.
  - Response: `pulse`=0 and `busy`=0 next cycle, `done` never asserts, and a new start is accepted afterwards.
  - With `TXN_GEN_STATS_EN`: `beat_total`=2.
- Reset mid-burst:
  - Stimulus: `rstn` low during beat 2.
  - Response: `pulse`, `addr`, `data`, `busy`, `done` and `beat_idx` go to 0 without waiting for a clock edge.
  - With `TXN_GEN_STATS_EN`: `beat_total`=0.

Source files
------------

// File: rtl/txn_gen_pkg.sv
// Shared types and constants for the burst transaction generator.
package txn_gen_pkg;

    localparam int STATS_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/txn_addr_step.sv
// Address/data accumulators: load on accepted start, step by stride / +1 per transfer.
// Registered outputs, one cycle from load/step; holds value when neither is asserted.
module txn_addr_step #(
    parameter type ADDR = bit [31:0],
    parameter type DATA = logic [7:0]
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic step,
    input  ADDR  base_addr,
    input  ADDR  stride,
    input  DATA  seed,
    output ADDR  addr,
    output DATA  data
);

    ADDR r_addr;
    ADDR r_stride;
    DATA r_data;

    // Accumulate rather than multiply: wraps naturally modulo the type width.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_data   <= '0;
        end else if (load) begin
            r_addr   <= base_addr;
            r_stride <= stride;
            r_data   <= seed;
        end else if (step) begin
            r_addr   <= ADDR'(r_addr + r_stride);
            r_data   <= DATA'(r_data + DATA'(1));
        end
    end

    assign addr = r_addr;
    assign data = r_data;

endmodule

// File: rtl/param_txn_gen.sv
// Burst generator: start in IDLE -> beat 0 valid next cycle, 1 beat/cycle, done strobe after last beat.
// Beats hold while ready=0; all outputs registered. Optional beat counter under TXN_GEN_STATS_EN.
module param_txn_gen
    import txn_gen_pkg::*;
#(
    parameter int  MSB  = 4,
    parameter type ADDR = bit [31:0],
    parameter type DATA = logic [7:0]
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         abort,
    input  ADDR          base_addr,
    input  ADDR          stride,
    input  DATA          seed,
    input  logic [MSB:0] len,
    input  logic         ready,
    output logic         pulse,
    output ADDR          addr,
    output DATA          data,
    output logic [MSB:0] beat_idx,
    output logic         busy,
    output logic         done
`ifdef TXN_GEN_STATS_EN
    ,
    output logic [STATS_W-1:0] beat_total
`endif
);

    state_t       r_state;
    logic         r_pulse;
    logic         r_busy;
    logic         r_done;
    logic [MSB:0] r_len;
    logic [MSB:0] r_beat_idx;

    logic         w_xfer;
    logic         w_load;
    logic         w_last;

    assign w_xfer = r_pulse & ready;
    assign w_load = (r_state == IDLE) & start & ~abort;
    assign w_last = (r_beat_idx == r_len - (MSB+1)'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_pulse    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_len      <= '0;
            r_beat_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_len      <= len;
                        r_beat_idx <= '0;
                        r_busy     <= 1'b1;
                        if (len != '0) begin
                            r_state <= RUN;
                            r_pulse <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A beat transferring alongside abort is still delivered.
                    if (abort) begin
                        r_state <= IDLE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_xfer) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_pulse <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_beat_idx <= r_beat_idx + (MSB+1)'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    txn_addr_step #(
        .ADDR (ADDR),
        .DATA (DATA)
    ) u_step (
        .clk       (clk),
        .rstn      (rstn),
        .load      (w_load),
        .step      (w_xfer),
        .base_addr (base_addr),
        .stride    (stride),
        .seed      (seed),
        .addr      (addr),
        .data      (data)
    );

    assign pulse    = r_pulse;
    assign busy     = r_busy;
    assign done     = r_done;
    assign beat_idx = r_beat_idx;

`ifdef TXN_GEN_STATS_EN
    logic [STATS_W-1:0] r_beat_total;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_total <= '0;
        end else if (w_xfer && (r_beat_total != '1)) begin
            r_beat_total <= r_beat_total + STATS_W'(1);
        end
    end

    assign beat_total = r_beat_total;
`endif

endmodule
